maxpool_backward: RTL and testbench
===================================

// Module: maxpool_backward
// PURPOSE
//  Backward pass of the max-pooling layer: routes each pooled gradient back to the argmax
//  position of its POOL x POOL window in the forward activation map; all other positions get 0.
//  Sits after the dense-layer backward path and feeds the conv-layer weight-update block.
//  Non-overlapping windows, stride = POOL; sequential single-comparator argmax scan.
// PARAMETERS
//  IN_DIM     28  side of forward activation map / gradient output map
//  POOL        2  pooling window side and stride; IN_DIM % POOL != 0 -> $error at elaboration
//  WIDTH_BIT  16  signed data width of activations and gradients
//  (localparam OUT_DIM = IN_DIM/POOL)
// PORTS
//  clock     in   1                              rising-edge clock
//  nreset    in   1                              asynchronous, active-low reset
//  start     in   1                              begin pass; sampled only in IDLE
//  busy      out  1                              high from edge after start until done cycle ends
//  done      out  1                              one-cycle completion pulse (registered)
//  act_in    in   [IN_DIM-1:0][IN_DIM-1:0]  x W  signed forward activations
//  grad_in   in   [OUT_DIM-1:0][OUT_DIM-1:0] x W signed gradients at pooled output
//  grad_out  out  [IN_DIM-1:0][IN_DIM-1:0]  x W  signed routed gradients (registered)
// BEHAVIOUR
//  Reset (async): state IDLE, busy=0, done=0, all grad_out=0, window counters i=j=0.
//  FSM: IDLE -> CLEAR -> {LOAD -> SCAN -> WRITE} per window -> DONE -> IDLE.
//   IDLE : start=1 -> CLEAR, busy<=1. start while not IDLE ignored.
//   CLEAR: all grad_out<=0, i=j=0 -> LOAD (1 cycle).
//   LOAD : latch window act_in[i*POOL+r][j*POOL+c]; best<=elem(0,0), bidx<=0, k<=1 -> SCAN.
//   SCAN : one element per cycle, k=1..POOL*POOL-1 row-major; if elem(k) > best (signed,
//          strict) then best<=elem(k), bidx<=k. After k=POOL*POOL-1 -> WRITE.
//   WRITE: grad_out[i*POOL+bidx/POOL][j*POOL+bidx%POOL] <= grad_in[i][j];
//          advance j (row-major), wrap j at OUT_DIM-1 to 0 and inc i; last window
//          (i=j=OUT_DIM-1) -> DONE with done<=1, else -> LOAD.
//   DONE : done=1, busy=1 for this one cycle; next edge done<=0, busy<=0 -> IDLE.
//  Cycles/window = POOL^2+1. done is high in the cycle after rising edge number
//   1 + OUT_DIM^2*(POOL^2+1) counted from the edge that sampled start (default: 981).
//  Ties: strict '>' keeps first maximum in row-major order (lowest r, then lowest c).
//  No arithmetic on gradients: pure copy, full WIDTH_BIT, no saturation.
//  act_in/grad_in are NOT snapshotted; caller holds them stable from start through done.
//  grad_out holds its value after done until CLEAR of the next pass; only one
//   grad_out element changes per WRITE cycle.
//  start asserted in DONE cycle is ignored (accepted only in IDLE, i.e. next cycle on).
//  nreset mid-pass: immediate abort, all state/outputs to reset values, no done pulse.
//  POOL=1: SCAN skipped (LOAD -> WRITE), grad_out = grad_in, 2 cycles/window.
// TESTING (IN_DIM=4, POOL=2, WIDTH_BIT=16 unless noted)
//  1 Distinct maxima: act rows {1,5,2,0},{3,4,9,8},{-1,-2,7,7},{-3,-4,6,0}, grad_in {{10,20},{30,40}}
//    -> grad_out[0][1]=10,[1][2]=20,[2][0]=30,[2][2]=40, other 12 = 0; done 21 cycles after start.
//  2 Ties/negatives: all act=-5, grad_in all 7 -> 7 at [0][0],[0][2],[2][0],[2][2] only.
//  3 Back-to-back: 2nd pass different grad_in with start in DONE cycle -> ignored;
//    start next cycle -> CLEAR zeroes stale values, new result correct; busy never gaps mid-pass.
//  4 Reset mid-pass: nreset low at cycle 10 -> busy=done=0, grad_out all 0 immediately;
//    restart completes correctly, no spurious done.
//  5 Extremes: act -32768 and 32767 in one window, grad_in=-32768 -> routed to 32767 position,
//    value -32768 exact (signed compare, no truncation).
//  6 IN_DIM=28 default random act/grad vs. reference model -> bit-exact grad_out, done at 981.

Source files
------------

// File: rtl/maxpool_backward_if.sv
// Bundle between the max-pool backward engine and its caller: start/busy/done
// control plus the activation, pooled-gradient and routed-gradient maps.
interface maxpool_backward_if #(
  parameter int IN_DIM    = 28,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 16
);
  localparam int OUT_DIM = IN_DIM / POOL;

  logic                                             start;
  logic                                             busy;
  logic                                             done;
  logic [IN_DIM-1:0][IN_DIM-1:0][WIDTH_BIT-1:0]     act_in;
  logic [OUT_DIM-1:0][OUT_DIM-1:0][WIDTH_BIT-1:0]   grad_in;
  logic [IN_DIM-1:0][IN_DIM-1:0][WIDTH_BIT-1:0]     grad_out;

  modport master (output start, act_in, grad_in, input busy, done, grad_out);
  modport slave  (input start, act_in, grad_in, output busy, done, grad_out);
endinterface

// File: rtl/maxpool_backward.sv
// Max-pool backward: routes each pooled gradient to the argmax of its window,
// POOL*POOL+1 cycles per window; caller holds act_in/grad_in stable while busy.
module maxpool_backward #(
  parameter int IN_DIM    = 28,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 16
) (
  input  logic               clock,
  input  logic               nreset,
  maxpool_backward_if.slave  bus
);
  localparam int OUT_DIM = IN_DIM / POOL;
  localparam int NWIN    = POOL * POOL;
  localparam int AW      = (IN_DIM > 1)  ? $clog2(IN_DIM)  : 1;
  localparam int OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int KW      = (NWIN > 1)    ? $clog2(NWIN)    : 1;

  if (IN_DIM % POOL != 0) begin : g_bad_pool
    $error("maxpool_backward: IN_DIM must be a multiple of POOL");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t                                       r_state, w_next;
  logic [OW-1:0]                                r_i, r_j;
  logic [KW-1:0]                                r_k, r_bidx;
  logic signed [WIDTH_BIT-1:0]                  r_best;
  logic [NWIN-1:0][WIDTH_BIT-1:0]               r_win;
  logic                                         r_busy, r_done;
  logic [IN_DIM-1:0][IN_DIM-1:0][WIDTH_BIT-1:0] r_grad_out;

  logic          w_last_k, w_last_win, w_better;
  logic [AW-1:0] w_row, w_col;

  always_comb begin
    w_last_k   = (r_k == KW'(NWIN - 1));
    w_last_win = (r_i == OW'(OUT_DIM - 1)) && (r_j == OW'(OUT_DIM - 1));
    w_better   = $signed(r_win[r_k]) > r_best;
    w_row      = AW'(r_i * POOL + r_bidx / POOL);
    w_col      = AW'(r_j * POOL + r_bidx % POOL);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_LOAD;
      S_LOAD:  w_next = (NWIN > 1) ? S_SCAN : S_WRITE;
      S_SCAN:  if (w_last_k) w_next = S_WRITE;
      S_WRITE: w_next = w_last_win ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_bidx     <= '0;
      r_best     <= '0;
      r_win      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_grad_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) r_busy <= 1'b1;
        S_CLEAR: begin
          r_grad_out <= '0;
          r_i        <= '0;
          r_j        <= '0;
        end
        S_LOAD: begin
          for (int r = 0; r < POOL; r++)
            for (int c = 0; c < POOL; c++)
              r_win[r*POOL+c] <= bus.act_in[AW'(r_i*POOL + r)][AW'(r_j*POOL + c)];
          r_best <= $signed(bus.act_in[AW'(r_i*POOL)][AW'(r_j*POOL)]);
          r_bidx <= '0;
          r_k    <= KW'(1);
        end
        S_SCAN: begin
          // Strict compare keeps the first maximum in row-major order.
          if (w_better) begin
            r_best <= $signed(r_win[r_k]);
            r_bidx <= r_k;
          end
          r_k <= r_k + KW'(1);
        end
        S_WRITE: begin
          r_grad_out[w_row][w_col] <= bus.grad_in[r_i][r_j];
          if (r_j == OW'(OUT_DIM - 1)) begin
            r_j <= '0;
            r_i <= r_i + OW'(1);
          end else begin
            r_j <= r_j + OW'(1);
          end
          if (w_last_win) r_done <= 1'b1;
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.grad_out = r_grad_out;
endmodule

// File: tb/tb_maxpool_backward.sv
// Directed + random checks of maxpool_backward at 4x4 and default 28x28 sizes
// against a window-by-window argmax reference model.
module tb_maxpool_backward;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  maxpool_backward_if #(.IN_DIM(4),  .POOL(2), .WIDTH_BIT(16)) bus4 ();
  maxpool_backward_if #(.IN_DIM(28), .POOL(2), .WIDTH_BIT(16)) bus28 ();

  maxpool_backward #(.IN_DIM(4),  .POOL(2), .WIDTH_BIT(16)) dut4  (.clock(clock), .nreset(nreset), .bus(bus4));
  maxpool_backward #(.IN_DIM(28), .POOL(2), .WIDTH_BIT(16)) dut28 (.clock(clock), .nreset(nreset), .bus(bus28));

  int n_checks = 0;
  int n_errs   = 0;
  int act[28][28];
  int grd[14][14];
  int expm[28][28];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: per window, scan row-major and keep the first strict maximum.
  task automatic model(input int n, input int p);
    int best, br, bc;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) expm[r][c] = 0;
    for (int wi = 0; wi < n / p; wi++)
      for (int wj = 0; wj < n / p; wj++) begin
        best = act[wi*p][wj*p]; br = 0; bc = 0;
        for (int r = 0; r < p; r++)
          for (int c = 0; c < p; c++)
            if (act[wi*p+r][wj*p+c] > best) begin
              best = act[wi*p+r][wj*p+c]; br = r; bc = c;
            end
        expm[wi*p+br][wj*p+bc] = grd[wi][wj];
      end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) expm[r][c] = 0;
  endtask

  task automatic apply4();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) bus4.act_in[r][c] = act[r][c][15:0];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) bus4.grad_in[r][c] = grd[r][c][15:0];
  endtask

  task automatic apply28();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) bus28.act_in[r][c] = act[r][c][15:0];
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) bus28.grad_in[r][c] = grd[r][c][15:0];
  endtask

  task automatic rand4(input int lo, input int hi);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) act[r][c] = int'($urandom_range(hi - lo, 0)) + lo;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) grd[r][c] = int'($urandom_range(65535, 0)) - 32768;
  endtask

  task automatic check_map4(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_go[%0d][%0d]", tag, r, c),
            {16'b0, bus4.grad_out[r][c]}, {16'b0, expm[r][c][15:0]});
  endtask

  task automatic check_map28(input string tag);
    int diffs, fr, fc;
    diffs = 0; fr = -1; fc = -1;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        if (bus28.grad_out[r][c] !== expm[r][c][15:0]) begin
          if (diffs == 0) begin fr = r; fc = c; end
          diffs++;
        end
    chk($sformatf("%s_diffs_first_at_%0d_%0d", tag, fr, fc), diffs, 0);
  endtask

  // Called right after start was raised at a negedge; counts edges to done.
  task automatic wait_done(input bit big, input int budget, output int lat, output bit gap);
    lat = 0; gap = 0;
    @(negedge clock);
    if (big) bus28.start = 1'b0; else bus4.start = 1'b0;
    while (((big ? bus28.done : bus4.done) !== 1'b1) && lat < budget) begin
      if ((big ? bus28.busy : bus4.busy) !== 1'b1) gap = 1'b1;
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  gap;
    bit  seen_done;
    int  t1a[4][4] = '{'{1, 5, 2, 0}, '{3, 4, 9, 8}, '{-1, -2, 7, 7}, '{-3, -4, 6, 0}};

    bus4.start = 1'b0; bus28.start = 1'b0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) act[r][c] = 0;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) grd[r][c] = 0;
    apply4(); apply28();

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy4", bus4.busy, 0);
    chk("rst_done4", bus4.done, 0);
    chk("rst_busy28", bus28.busy, 0);
    chk("rst_done28", bus28.done, 0);
    clear_exp();
    check_map4("rst");
    nreset = 1'b1;
    @(negedge clock);

    // Test 1: distinct maxima
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) act[r][c] = t1a[r][c];
    grd[0][0] = 10; grd[0][1] = 20; grd[1][0] = 30; grd[1][1] = 40;
    apply4();
    clear_exp();
    expm[0][1] = 10; expm[1][2] = 20; expm[2][0] = 30; expm[2][2] = 40;
    bus4.start = 1'b1;
    wait_done(1'b0, 200, lat, gap);
    chk("t1_latency", lat, 21);
    chk("t1_busy_gap", {31'b0, gap}, 0);
    check_map4("t1");

    // Test 3: start during DONE is ignored, start one cycle later is taken
    rand4(-10, 10);
    apply4();
    model(4, 2);
    bus4.start = 1'b1;
    @(negedge clock);
    chk("t3_idle_busy", bus4.busy, 0);
    chk("t3_idle_done", bus4.done, 0);
    wait_done(1'b0, 200, lat, gap);
    chk("t3_latency", lat, 21);
    chk("t3_busy_gap", {31'b0, gap}, 0);
    check_map4("t3");
    @(negedge clock);
    chk("t3_after_done", bus4.done, 0);
    chk("t3_after_busy", bus4.busy, 0);

    // Test 2: all ties, negative activations
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) act[r][c] = -5;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) grd[r][c] = 7;
    apply4();
    clear_exp();
    expm[0][0] = 7; expm[0][2] = 7; expm[2][0] = 7; expm[2][2] = 7;
    bus4.start = 1'b1;
    wait_done(1'b0, 200, lat, gap);
    chk("t2_latency", lat, 21);
    check_map4("t2");
    @(negedge clock);

    // Test 4: reset mid-pass, then clean restart
    rand4(-10, 10);
    grd[0][0] = 1234;
    apply4();
    bus4.start = 1'b1;
    @(negedge clock);
    bus4.start = 1'b0;
    repeat (9) @(negedge clock);
    chk("t4_pre_busy", bus4.busy, 1);
    nreset = 1'b0;
    #1;
    chk("t4_rst_busy", bus4.busy, 0);
    chk("t4_rst_done", bus4.done, 0);
    clear_exp();
    check_map4("t4_rst");
    @(negedge clock);
    nreset = 1'b1;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (bus4.done !== 1'b0) seen_done = 1'b1;
    end
    chk("t4_no_spurious_done", {31'b0, seen_done}, 0);
    model(4, 2);
    bus4.start = 1'b1;
    wait_done(1'b0, 200, lat, gap);
    chk("t4_latency", lat, 21);
    check_map4("t4");
    @(negedge clock);

    // Test 5: extreme values in one window
    rand4(-100, 100);
    act[0][0] = -32768; act[0][1] = 32767; act[1][0] = 0; act[1][1] = 32767;
    grd[0][0] = -32768;
    apply4();
    model(4, 2);
    bus4.start = 1'b1;
    wait_done(1'b0, 200, lat, gap);
    chk("t5_latency", lat, 21);
    chk("t5_extreme", {16'b0, bus4.grad_out[0][1]}, 32'h0000_8000);
    chk("t5_tie_second", {16'b0, bus4.grad_out[1][1]}, 0);
    check_map4("t5");
    @(negedge clock);

    // Test 6: default size, random maps with frequent ties
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) act[r][c] = int'($urandom_range(15, 0)) - 8;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++) grd[r][c] = int'($urandom_range(65535, 0)) - 32768;
    apply28();
    model(28, 2);
    bus28.start = 1'b1;
    wait_done(1'b1, 3000, lat, gap);
    chk("t6_latency", lat, 981);
    chk("t6_busy_gap", {31'b0, gap}, 0);
    check_map28("t6");
    @(negedge clock);
    chk("t6_after_done", bus28.done, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
